mac_accumulator: RTL and testbench

Pipelined signed multiply-accumulate stage built around the team's combinational 16x16 signed multiplier (`TopMultiplier`).
- Accepts a stream of operand pairs over a valid/ready handshake and registers them before the multiplier.
- Registers the 32-bit product, then sign-extends it and sums it into a wide accumulator.
- Emits one dot-product result per `in_last`-terminated vector over a second valid/ready handshake.

---
 rtl/mac_accumulator.sv | 147 ++++++++++++++
 tb/tb_mac_accumulator.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Pipelined signed 16x16 multiply-accumulate: one dot-product result per in_last-terminated vector.
// Build macro MAC_SATURATE_EN selects a saturating accumulator with a sticky ovf flag (default: wrap, ovf=0).
module TopMultiplier (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

module mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      x_in,
  input  logic signed [15:0]      y_in,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic [LEN_W-1:0]        out_count,
  output logic                    ovf
);
  logic signed [15:0]      x_p1, y_p1;
  logic                    vld_p1, last_p1;
  logic signed [31:0]      prod;
  logic signed [31:0]      prod_p2;
  logic                    vld_p2, last_p2;
  logic signed [ACC_W-1:0] acc;
  logic [LEN_W-1:0]        cnt;
  logic signed [ACC_W-1:0] sum;
  logic                    stall;

  // Only a last element blocked by an unconsumed result freezes the pipe.
  assign stall    = out_valid & ~out_ready & vld_p2 & last_p2;
  assign in_ready = ~stall;

  // ---- S1: operand register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1  <= in_valid;
      last_p1 <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      x_p1 <= x_in;
      y_p1 <= y_in;
    end
  end

  TopMultiplier u_mult (
    .a(x_p1),
    .b(y_p1),
    .p(prod)
  );

  // ---- S2: product register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) prod_p2 <= prod;
  end

  // ---- S3: accumulate and emit ----
`ifdef MAC_SATURATE_EN
  function automatic logic sum_overflows(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  localparam int SUM_W = ACC_W + 1;
  logic signed [ACC_W:0] sum_wide;
  logic                  sum_ovf;
  logic                  ovf_sticky, ovf_q;

  // One guard bit exposes signed overflow before clamping.
  assign sum_wide = SUM_W'(acc) + SUM_W'(prod_p2);
  assign sum_ovf  = sum_overflows(sum_wide);
  assign sum      = sat_acc(sum_wide);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (vld_p2 && !stall) begin
      if (last_p2) begin
        ovf_q      <= ovf_sticky | sum_ovf;
        ovf_sticky <= 1'b0;
      end else begin
        ovf_sticky <= ovf_sticky | sum_ovf;
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign sum = acc + ACC_W'(prod_p2);
  assign ovf = 1'b0;
`endif

  // A handshake clears out_valid unless a fresh result lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (vld_p2 && !stall) begin
        if (last_p2) begin
          acc_out   <= sum;
          out_count <= cnt + LEN_W'(1);
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + LEN_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a 40-bit and a 33-bit instance share one stimulus stream.
// Expected results come from plain integer dot products with wrap or clamp per MAC_SATURATE_EN.
module tb_mac_accumulator;
  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b1;
  logic               in_valid, in_last;
  logic signed [15:0] x_in, y_in;
  logic               out_ready = 1'b0;
  logic               ready_req = 1'b0;
  logic               bp_mode = 1'b0;

  logic               in_ready_a, in_ready_b, out_valid_a, out_valid_b, ovf_a, ovf_b;
  logic signed [39:0] acc_a;
  logic signed [32:0] acc_b;
  logic [7:0]         cnt_a, cnt_b;

  mac_accumulator #(.ACC_W(40), .LEN_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .x_in(x_in), .y_in(y_in), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .acc_out(acc_a), .out_count(cnt_a), .ovf(ovf_a)
  );

  mac_accumulator #(.ACC_W(33), .LEN_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .x_in(x_in), .y_in(y_in), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .acc_out(acc_b), .out_count(cnt_b), .ovf(ovf_b)
  );

  exp_t   q_a[$], q_b[$];
  exp_t   ea, eb;
  int     errors = 0;
  int     checks = 0;
  longint m_acc[2];
  bit     m_ovf[2];
  int     m_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Running dot product per instance width; pushes the expected result on the last element.
  task automatic model_accept(input logic signed [15:0] x, input logic signed [15:0] y, input bit last);
    longint p, s, half;
    int     w;
    exp_t   e;
    p = longint'(x) * longint'(y);
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 40 : 33;
      half = longint'(1) << (w - 1);
      s = m_acc[i] + p;
`ifdef MAC_SATURATE_EN
      if (s > half - 1) begin
        s = half - 1;
        m_ovf[i] = 1'b1;
      end else if (s < -half) begin
        s = -half;
        m_ovf[i] = 1'b1;
      end
`else
      s = ((s + half) % (2 * half) + 2 * half) % (2 * half) - half;
`endif
      m_acc[i] = s;
    end
    m_cnt++;
    if (last) begin
      e.cnt = m_cnt % 256;
      e.acc = m_acc[0];
      e.ovf = m_ovf[0];
      q_a.push_back(e);
      e.acc = m_acc[1];
      e.ovf = m_ovf[1];
      q_b.push_back(e);
      model_clear();
    end
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : ready_req;
  end

  // Monitor: a result is consumed on the next edge whenever valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_a: got acc %0d with nothing expected", acc_a);
      end else begin
        ea = q_a.pop_front();
        chk("acc_a", longint'(acc_a), ea.acc);
        chk("cnt_a", longint'(cnt_a), longint'(ea.cnt));
        chk("ovf_a", longint'(ovf_a), longint'(ea.ovf));
      end
    end
    if (rst_n && out_valid_b && out_ready) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_b: got acc %0d with nothing expected", acc_b);
      end else begin
        eb = q_b.pop_front();
        chk("acc_b", longint'(acc_b), eb.acc);
        chk("cnt_b", longint'(cnt_b), longint'(eb.cnt));
        chk("ovf_b", longint'(ovf_b), longint'(eb.ovf));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the pair.
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, input bit last);
    int g;
    g = 0;
    in_valid = 1'b1;
    x_in = x;
    y_in = y;
    in_last = last;
    @(negedge clk);
    while (!in_ready_a && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready_a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready %0d, required 1", in_ready_a);
    end else begin
      model_accept(x, y, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && g < 300) begin
      @(posedge clk);
      g++;
    end
    #1;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d and %0d results outstanding, required 0", q_a.size(), q_b.size());
    end
    idle(1);
  endtask

  initial begin
    logic signed [15:0] rx, ry;
    int len, g;
    in_valid = 1'b0;
    in_last = 1'b0;
    x_in = '0;
    y_in = '0;
    model_clear();

    #1 rst_n = 1'b0;
    #12;
    chk("rst0_out_valid", longint'(out_valid_a), 0);
    chk("rst0_in_ready", longint'(in_ready_a), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_req = 1'b1;
    idle(2);

    // Reset mid-vector while an earlier result is still waiting
    ready_req = 1'b0;
    send(9, 9, 1'b1);
    send(1, 2, 1'b0);
    send(3, 4, 1'b0);
    idle(2);
    chk("pending_before_reset", longint'(out_valid_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", longint'(out_valid_a), 0);
    chk("rst_acc_out", longint'(acc_a), 0);
    chk("rst_out_count", longint'(cnt_a), 0);
    chk("rst_ovf", longint'(ovf_a), 0);
    chk("rst_in_ready", longint'(in_ready_a), 1);
    chk("rst_out_valid_b", longint'(out_valid_b), 0);
    q_a.delete();
    q_b.delete();
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_req = 1'b1;
    idle(1);
    send(1, 1, 1'b0);
    send(2, 2, 1'b1);
    drain();

    // Dot product with latency and single-cycle valid
    send(3, 4, 1'b0);
    send(-2, 5, 1'b0);
    send(100, -100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("dot_valid_c%0d", k), longint'(out_valid_a), longint'(k == 2));
    end
    @(posedge clk);
    #1;
    drain();

    send(-32768, -32768, 1'b1);
    send(-32768, 32767, 1'b1);
    drain();

    // Backpressure: second last element stalls behind the held first result
    ready_req = 1'b0;
    idle(1);
    send(2, 3, 1'b1);
    send(4, 5, 1'b1);
    idle(3);
    chk("bp_in_ready", longint'(in_ready_a), 0);
    chk("bp_out_valid", longint'(out_valid_a), 1);
    chk("bp_held_acc", longint'(acc_a), 6);
    chk("bp_held_cnt", longint'(cnt_a), 1);
    idle(2);
    chk("bp_still_held", longint'(acc_a), 6);
    ready_req = 1'b1;
    drain();
    chk("bp_in_ready_after", longint'(in_ready_a), 1);

    // Five maximal products overflow the 33-bit accumulator
    ready_req = 1'b0;
    idle(1);
    for (int i = 0; i < 5; i++) send(-32768, -32768, i == 4);
    g = 0;
    while (!out_valid_b && g < 10) begin
      @(negedge clk);
      g++;
    end
`ifdef MAC_SATURATE_EN
    chk("sat_acc_b", longint'(acc_b), 64'sd4294967295);
    chk("sat_ovf_b", longint'(ovf_b), 1);
`else
    chk("wrap_acc_b", longint'(acc_b), -64'sd3221225472);
    chk("wrap_ovf_b", longint'(ovf_b), 0);
`endif
    @(posedge clk);
    #1;
    ready_req = 1'b1;
    drain();

    send(1, 7, 1'b1);
    idle(2);
    send(2, -3, 1'b0);
    send(1, 1, 1'b1);
    drain();

    // Element counter wraps at 256
    for (int i = 0; i < 257; i++) send(1, 1, i == 256);
    drain();

    // Random vectors, bubbles and random output backpressure
    bp_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      len = $urandom_range(1, 6);
      for (int e = 0; e < len; e++) begin
        rx = ($urandom_range(0, 7) == 0) ? -16'sd32768 : 16'($urandom);
        ry = ($urandom_range(0, 7) == 0) ? -16'sd32768 : 16'($urandom);
        send(rx, ry, e == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    bp_mode = 1'b0;
    ready_req = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
